// File: rtl/rr_pipe_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_pipe_mux
// Purpose  : Registered N-to-1 valid/ready mux with round-robin or
//            fixed-priority arbitration and a one-entry output register.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pipe_mux #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1,
  parameter int MODE     = 0,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]       o_ready,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]          o_sel,
  input  logic                      i_ready
);

  localparam logic [SEL_W-1:0] c_ptr_rst = SEL_W'(CHANNELS - 1);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic             w_found;
  logic [SEL_W-1:0] w_grant;

  assign w_load = !r_valid | i_ready;

  // Round-robin scans from the slot after the last grant; the modulo keeps
  // the scan inside 0..CHANNELS-1 for non-power-of-two channel counts.
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (MODE == 0) ? ((int'(r_ptr) + 1 + i) % CHANNELS) : i;
      if (!w_found && i_valid[idx]) begin
        w_found = 1'b1;
        w_grant = SEL_W'(idx);
      end
    end
  end

  assign o_ready = (w_load && w_found) ? (CHANNELS'(1) << w_grant) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= c_ptr_rst;
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_data  <= i_data[int'(w_grant)*WIDTH +: WIDTH];
        r_sel   <= w_grant;
        if (MODE == 0) r_ptr <= w_grant;
      end else begin
        r_valid <= 1'b0;
      end
    end

    if (!i_rst) begin
      assert ($onehot0(o_ready))
        else $error("rr_pipe_mux: o_ready is not onehot0");
      assert (!r_valid || (int'(r_sel) < CHANNELS))
        else $error("rr_pipe_mux: o_sel out of range while o_valid");
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sel   = r_sel;

endmodule
`default_nettype wire
